// File: rtl/opb_sw_reg_bank_pkg.sv
// Shared types and helpers for the OPB software register bank.
// - Transfer FSM state encoding.
// - Byte-lane merge helper.
// - Address-to-word-index helper.
package opb_sw_reg_bank_pkg;

  // Transfer FSM: IDLE waits for a hit, ACK is the single acknowledge cycle,
  // WAIT holds off until the master drops select so each select gets one ack.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } opb_state_e;

  // Bytes per register word.
  localparam int REG_BYTES = 4;

  // Merge write data into an old register value, one byte lane at a time.
  // be_v[3] corresponds to OPB_BE[0] and selects bits 31:24 (big-endian lane
  // numbering on the bus maps onto the high end of the little-endian vector).
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] data_v,
                                           input logic [3:0]  be_v);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < REG_BYTES; b++) begin
      if (be_v[b]) begin
        res[8*b +: 8] = data_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Word offset of a byte address from the window base; the two byte-select
  // bits are dropped so unaligned addresses map onto their containing word.
  function automatic logic [29:0] addr_to_idx(input logic [31:0] addr_v,
                                              input logic [31:0] base_v);
    return 30'((addr_v - base_v) >> 2);
  endfunction

endpackage

// File: rtl/opb_sw_reg_decode.sv
// Combinational address decode for the OPB software register bank.
// - hit_o: transfer qualified by select and inside the byte window.
// - in_range_o: hit that lands on an implemented register.
// - idx_o: register index (only meaningful when in_range_o is set).
module opb_sw_reg_decode
  import opb_sw_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0100_0100,
  parameter logic [31:0] C_HIGHADDR = 32'h0100_01FF,
  parameter int          C_NUM_REGS = 4,
  parameter int          IDX_W      = 2
) (
  input  logic [31:0]      addr_i,
  input  logic             select_i,
  output logic             hit_o,
  output logic             in_range_o,
  output logic [IDX_W-1:0] idx_o
);

  logic        in_win_s;
  logic [29:0] word_s;

  assign in_win_s   = (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
  assign word_s     = addr_to_idx(addr_i, C_BASEADDR);
  assign hit_o      = select_i & in_win_s;
  // The full word offset is compared so window slots past the last register
  // never alias onto a real one through index truncation.
  assign in_range_o = hit_o & (word_s < 30'(C_NUM_REGS));
  assign idx_o      = word_s[IDX_W-1:0];

endmodule

// File: rtl/opb_sw_reg_bank.sv
// OPB slave exposing C_NUM_REGS software-writable/readable 32-bit registers.
// - Two-cycle transfers: ack one cycle after the first hit, then WAIT until
//   select drops so every select assertion is acknowledged exactly once.
// - Byte-enable writes with a one-cycle strobe coincident with the new value.
// - Registers flagged in C_PULSE_MASK clear one cycle after being written.
// - Optional macro OPB_SW_REG_BANK_ERRACK_EN: window slots without a register
//   are answered with Sl_errAck instead of Sl_xferAck.
module opb_sw_reg_bank
  import opb_sw_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_01FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = 64'h0,
  parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_stb
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  // Bus views renumbered so bit 31 is the MSB (OPB bit 0).
  logic [31:0]      addr_s;
  logic [31:0]      wdata_s;
  logic [3:0]       be_s;

  // Decode results
  logic             hit_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;

  // Control
  opb_state_e       state_q, state_d;
  logic             start_s;
  logic             write_s;

  // Transfer attributes captured at the hit so the ACK cycle does not depend
  // on the master keeping the bus stable once select may have dropped.
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rnw_q, rnw_d;
  logic             in_range_q, in_range_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  // Registered bus responses
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  // Register array and strobes
  logic [31:0]            regs_q [C_NUM_REGS];
  logic [31:0]            regs_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]  stb_q, stb_d;

  // All OPB transfers are treated as single beats.
  logic unused_s;
  assign unused_s = OPB_seqAddr;

  assign addr_s  = OPB_ABus;
  assign wdata_s = OPB_DBus;
  assign be_s    = OPB_BE;

  opb_sw_reg_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_NUM_REGS (C_NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr_i     (addr_s),
    .select_i   (OPB_select),
    .hit_o      (hit_s),
    .in_range_o (in_range_s),
    .idx_o      (idx_s)
  );

  assign start_s = (state_q == ST_IDLE) && hit_s;
  assign write_s = (state_q == ST_ACK) && !rnw_q && in_range_q;

  // Next-state logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        // A master that already released select needs no WAIT phase.
        if (OPB_select) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!OPB_select) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the transfer attributes on the first hit cycle.
  always_comb begin
    idx_d      = idx_q;
    rnw_d      = rnw_q;
    in_range_d = in_range_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if (start_s) begin
      idx_d      = idx_s;
      rnw_d      = OPB_RNW;
      in_range_d = in_range_s;
      wdata_d    = wdata_s;
      be_d       = be_s;
    end else begin
      idx_d      = idx_q;
      rnw_d      = rnw_q;
      in_range_d = in_range_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
    end
  end

  // Acknowledge type for the upcoming ACK cycle.
  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
`ifdef OPB_SW_REG_BANK_ERRACK_EN
    if (start_s) begin
      ack_d = in_range_s;
      err_d = !in_range_s;
    end else begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end
`else
    if (start_s) begin
      ack_d = 1'b1;
    end else begin
      ack_d = 1'b0;
    end
    err_d = 1'b0;
`endif
  end

  // Register writes, pulse clearing and write strobes.
  always_comb begin
    regs_d = regs_q;
    stb_d  = {C_NUM_REGS{1'b0}};
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (write_s && (idx_q == IDX_W'(i))) begin
        regs_d[i] = be_merge(regs_q[i], wdata_q, be_q);
        stb_d[i]  = 1'b1;
      end else if (C_PULSE_MASK[i] && stb_q[i]) begin
        // Pulse register: the written value was visible for its strobe cycle.
        regs_d[i] = 32'h0000_0000;
        stb_d[i]  = 1'b0;
      end else begin
        regs_d[i] = regs_q[i];
        stb_d[i]  = 1'b0;
      end
    end
  end

  // Read data for the ACK cycle; regs_d is the value the register holds
  // during ACK, so the readback is registered yet still current.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (start_s && OPB_RNW && in_range_s) begin
      rdata_d = regs_d[idx_s];
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // State, captured attributes, responses and register array.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      rnw_q      <= 1'b0;
      in_range_q <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'h0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      stb_q      <= {C_NUM_REGS{1'b0}};
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs_q[i] <= C_RESET_VAL;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rnw_q      <= rnw_d;
      in_range_q <= in_range_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      stb_q      <= stb_d;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign Sl_DBus     = rdata_q;
  assign Sl_xferAck  = ack_q;
  assign Sl_errAck   = err_q;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_wr_stb = stb_q;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_opb_sw_reg_bank.sv
// Self-checking bench for opb_sw_reg_bank (4 registers, register 3 is a pulse
// register). A transaction-level model writes expected outputs into per-cycle
// timelines; a compare process checks every cycle against them.
module tb_opb_sw_reg_bank;

  localparam logic [31:0] BASE  = 32'h0100_0100;
  localparam logic [31:0] HIGH  = 32'h0100_01FF;
  localparam logic [3:0]  PULSE = 4'b1000;
  localparam int          NCYC  = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:31]  abus, dbus_w, sl_dbus;
  logic [0:3]   be;
  logic         rnw, sel, seq;
  logic         xack, eack, retry, tout;
  logic [127:0] udo;
  logic [3:0]   stb;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Expected per-cycle outputs
  bit          exp_ack_tl [NCYC];
  bit          exp_err_tl [NCYC];
  logic [31:0] exp_dbus_tl[NCYC];
  logic [3:0]  exp_stb_tl [NCYC];
  logic [31:0] exp_reg_tl [4][NCYC];

  // Per-transaction observations
  logic [31:0] r_rd;
  int          r_acks, r_errs, r_ack_k, r_stb_cyc, r_pls;
  logic [3:0]  r_stb_or;

  opb_sw_reg_bank #(.C_PULSE_MASK(64'h8)) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus_w),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (xack),
    .Sl_errAck     (eack),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout),
    .user_data_out (udo),
    .user_wr_stb   (stb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %h, required %h", name, cyc, act, req);
    end
  endtask

  // Outcome of one access started in cycle t: ack at t+1, new value and
  // strobe from t+2, pulse registers back to zero from t+3.
  function automatic void model_access(input logic [31:0] addr, input logic rnw_v,
                                       input logic [0:3] be_v, input logic [31:0] data_v,
                                       input int t);
    int widx;
    logic [31:0] newv;
    if (addr >= BASE && addr <= HIGH && t + 3 < NCYC) begin
      widx = int'((addr - BASE) / 32'd4);
      if (widx < 4) begin
        exp_ack_tl[t+1] = 1'b1;
        if (rnw_v) begin
          exp_dbus_tl[t+1] = exp_reg_tl[widx][t+1];
        end else begin
          newv = exp_reg_tl[widx][t+1];
          for (int k = 0; k < 4; k++)
            if (be_v[k]) newv[31-8*k -: 8] = data_v[31-8*k -: 8];
          exp_stb_tl[t+2][widx] = 1'b1;
          for (int c = t + 2; c < NCYC; c++)
            exp_reg_tl[widx][c] = (PULSE[widx] && c > t + 2) ? 32'h0 : newv;
        end
      end else begin
`ifdef OPB_SW_REG_BANK_ERRACK_EN
        exp_err_tl[t+1] = 1'b1;
`else
        exp_ack_tl[t+1] = 1'b1;
`endif
      end
    end
  endfunction

  // Drive one transfer: select held for 'hold' cycles, then 'gap' idle cycles.
  task automatic xact(input logic [31:0] addr, input logic rnw_v, input logic [0:3] be_v,
                      input logic [31:0] data_v, input int hold, input int gap);
    model_access(addr, rnw_v, be_v, data_v, cyc);
    r_rd = 32'h0; r_acks = 0; r_errs = 0; r_ack_k = -1;
    r_stb_or = 4'h0; r_stb_cyc = 0; r_pls = 0;
    abus = addr; rnw = rnw_v; be = be_v; dbus_w = data_v; sel = 1'b1;
    for (int k = 0; k < hold + gap; k++) begin
      if (k == hold) begin
        sel = 1'b0; abus = 32'h0; rnw = 1'b0; be = 4'h0; dbus_w = 32'h0;
      end
      @(negedge clk);
      if (xack) begin
        r_acks++;
        r_rd = sl_dbus;
        if (r_ack_k < 0) r_ack_k = k;
      end
      if (eack) r_errs++;
      r_stb_or = r_stb_or | stb;
      if (stb != 4'h0) r_stb_cyc++;
      if (udo[96]) r_pls++;
      @(posedge clk); #1;
    end
  endtask

  // Cycle-by-cycle comparison against the model timelines.
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      chk("xferAck", 32'(xack), 32'(exp_ack_tl[cyc]));
      chk("errAck", 32'(eack), 32'(exp_err_tl[cyc]));
      chk("Sl_DBus", sl_dbus, exp_dbus_tl[cyc]);
      chk("wr_stb", 32'(stb), 32'(exp_stb_tl[cyc]));
      chk("retry_tout", 32'({retry, tout}), 32'h0);
      for (int i = 0; i < 4; i++)
        chk("user_data", udo[32*i +: 32], exp_reg_tl[i][cyc]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    for (int c = 0; c < NCYC; c++) begin
      exp_ack_tl[c] = 1'b0; exp_err_tl[c] = 1'b0;
      exp_dbus_tl[c] = 32'h0; exp_stb_tl[c] = 4'h0;
      for (int i = 0; i < 4; i++) exp_reg_tl[i][c] = 32'h0;
    end
    rst = 1'b1; sel = 1'b0; abus = 32'h0; dbus_w = 32'h0; be = 4'h0;
    rnw = 1'b0; seq = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_udo_lo", udo[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    chk("reset_udo_hi", udo[127:64] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    chk("reset_ack", 32'(xack), 32'h0);

    // Read all registers after reset; ack in the cycle after select
    for (int i = 0; i < 4; i++) begin
      xact(BASE + 32'(4 * i), 1'b1, 4'hF, 32'h0, 2, 1);
      chk("rst_read_data", r_rd, 32'h0);
      chk("rst_read_acks", 32'(r_acks), 32'h1);
      chk("ack_latency", 32'(r_ack_k), 32'h1);
    end

    // Full-word write and readback, strobe on register 1 only, one cycle
    xact(BASE + 32'h4, 1'b0, 4'hF, 32'hDEAD_BEEF, 2, 2);
    chk("wr1_stb", 32'(r_stb_or), 32'h2);
    chk("wr1_stb_cycles", 32'(r_stb_cyc), 32'h1);
    xact(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 2, 1);
    chk("rd1_data", r_rd, 32'hDEAD_BEEF);

    // Byte-lane merge on register 0
    xact(BASE, 1'b0, 4'hF, 32'h1122_3344, 2, 1);
    xact(BASE, 1'b0, 4'b0101, 32'hAABB_CCDD, 1, 2);
    xact(BASE + 32'h2, 1'b1, 4'hF, 32'h0, 2, 1);
    chk("merge_data", r_rd, 32'h11BB_33DD);

    // Pulse register 3: visible exactly one cycle, reads back 0
    xact(BASE + 32'hC, 1'b0, 4'hF, 32'h0000_0001, 2, 3);
    chk("pulse_cycles", 32'(r_pls), 32'h1);
    xact(BASE + 32'hC, 1'b1, 4'hF, 32'h0, 2, 1);
    chk("pulse_readback", r_rd, 32'h0);

    // Select held 5 cycles: single ack
    xact(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 5, 1);
    chk("long_select_acks", 32'(r_acks), 32'h1);
    chk("long_select_data", r_rd, 32'hDEAD_BEEF);

    // Outside the window: no response at all
    xact(32'h0100_0080, 1'b1, 4'hF, 32'h0, 3, 1);
    chk("outside_acks", 32'(r_acks + r_errs), 32'h0);

    // Inside the window but beyond the last register
    xact(BASE + 32'h40, 1'b0, 4'hF, 32'hFFFF_FFFF, 2, 2);
`ifdef OPB_SW_REG_BANK_ERRACK_EN
    chk("oor_wr_err", 32'(r_errs), 32'h1);
    chk("oor_wr_ack", 32'(r_acks), 32'h0);
`else
    chk("oor_wr_ack", 32'(r_acks), 32'h1);
    chk("oor_wr_err", 32'(r_errs), 32'h0);
`endif
    chk("oor_wr_stb", 32'(r_stb_or), 32'h0);
    xact(BASE + 32'h40, 1'b1, 4'hF, 32'h0, 2, 1);
    chk("oor_rd_data", r_rd, 32'h0);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
        7:       a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 59)) + 32'($urandom_range(0, 3));
        8:       a = BASE - 32'h1 - 32'($urandom_range(0, 255));
        default: a = HIGH + 32'h1 + 32'($urandom_range(0, 255));
      endcase
      xact(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(1, 5), $urandom_range(1, 3));
    end

    // Reset asserted during the ACK cycle
    xact(BASE + 32'h4, 1'b0, 4'hF, 32'h5A5A_5A5A, 2, 1);
    chk_en = 1'b0;
    abus = BASE + 32'h4; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    @(posedge clk); #1;
    chk("ack_before_reset", 32'(xack), 32'h1);
    chk("reg1_before_reset", udo[63:32], 32'h5A5A_5A5A);
    rst = 1'b1;
    #1;
    chk("ack_during_reset", 32'(xack), 32'h0);
    chk("dbus_during_reset", sl_dbus, 32'h0);
    chk("stb_during_reset", 32'(stb), 32'h0);
    for (int i = 0; i < 4; i++)
      chk("regs_after_reset", udo[32*i +: 32], 32'h0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ack_after_reset", 32'(xack), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
